// File: rtl/huff_rle_expander.sv
// huff_rle_expander
// Takes one decoded Huffman symbol at a time and expands it into the 64
// coefficients of an 8x8 block, in zig-zag order. It handles DC
// prediction, AC zero runs, ZRL (16 zeros) and EOB fill.
//
// Ports
//   phi1         clock; all state changes on the rising edge
//   reset_b      asynchronous active-low reset
//   restart_s    synchronous restart pulse; clears predictor, index, err
//                and any coefficient still being presented
//   sym_valid    a symbol is presented on run_length/coeff_size/coefficient
//   sym_ready    a symbol can be accepted this cycle
//   run_length   zeros that precede the value (AC symbols only)
//   coeff_size   magnitude category 0..10 (11..15 flag err and act as 10)
//   coefficient  raw bitstream bits; only the low coeff_size bits are used
//   coef_valid   a coefficient is presented
//   coef_ready   the consumer takes the coefficient on this edge
//   coef_data    signed 12-bit coefficient
//   coef_index   zig-zag position, 0..63
//   block_end    marks the coefficient at index 63
//   err          sticky protocol error flag
module huff_rle_expander (
    input  logic        phi1,
    input  logic        reset_b,
    input  logic        restart_s,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [3:0]  run_length,
    input  logic [3:0]  coeff_size,
    input  logic [9:0]  coefficient,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic [11:0] coef_data,
    output logic [5:0]  coef_index,
    output logic        block_end,
    output logic        err
);

    typedef enum logic [2:0] {
        DC_WAIT  = 3'd0,
        DC_OUT   = 3'd1,
        AC_WAIT  = 3'd2,
        ZERO_RUN = 3'd3,
        VAL_OUT  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [11:0] pred_reg,  pred_next;
    logic [11:0] val_reg,   val_next;      // value waiting to be shown, or being shown
    logic [5:0]  idx_reg,   idx_next;      // index being shown, or the next free index while waiting
    logic [5:0]  zcnt_reg,  zcnt_next;     // zeros still to emit, including the one being shown
    logic        has_val_reg, has_val_next;
    logic        err_reg,   err_next;

    // ---------------- symbol decode ----------------
    logic        size_bad;
    logic [3:0]  s_eff;
    logic [11:0] mask;
    logic [11:0] v_raw;
    logic [11:0] top_bit;
    logic        v_msb;
    logic [11:0] value;
    logic        zero_size;
    logic        is_zrl;
    logic        is_eob_like;
    logic        illegal_rl;
    logic [6:0]  ac_span;
    logic [6:0]  last_pos;
    logic        overrun;
    logic [5:0]  fill_cnt;

    always_comb begin
        size_bad    = (coeff_size > 4'd10);
        s_eff       = size_bad ? 4'd10 : coeff_size;
        mask        = (12'd1 << s_eff) - 12'd1;
        v_raw       = {2'b00, coefficient} & mask;
        // The highest set bit of the mask selects v[s-1] without a variable
        // index. When s=0 the mask is zero, so the result is 0 - 0 = 0.
        top_bit     = mask ^ (mask >> 1);
        v_msb       = |(v_raw & top_bit);
        value       = v_msb ? v_raw : (v_raw - mask);

        zero_size   = (coeff_size == 4'd0);
        is_zrl      = zero_size && (run_length == 4'd15);
        is_eob_like = zero_size && !is_zrl;
        illegal_rl  = is_eob_like && (run_length != 4'd0);

        // Index of the last coefficient this AC symbol would produce.
        // Bit 6 set means the symbol would run past 63.
        ac_span     = is_zrl ? 7'd15 : {3'b000, run_length};
        last_pos    = {1'b0, idx_reg} + ac_span;
        overrun     = !is_eob_like && last_pos[6];

        // Zeros needed to fill through 63 is 64 - idx. An AC symbol always
        // starts at idx >= 1, so the 6-bit negation gives the exact count.
        fill_cnt    = 6'd0 - idx_reg;
    end

    // ---------------- state register ----------------
    always_ff @(posedge phi1 or negedge reset_b) begin
        if (!reset_b) begin
            state_reg   <= DC_WAIT;
            pred_reg    <= 12'd0;
            val_reg     <= 12'd0;
            idx_reg     <= 6'd0;
            zcnt_reg    <= 6'd0;
            has_val_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pred_reg    <= pred_next;
            val_reg     <= val_next;
            idx_reg     <= idx_next;
            zcnt_reg    <= zcnt_next;
            has_val_reg <= has_val_next;
            err_reg     <= err_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next   = state_reg;
        pred_next    = pred_reg;
        val_next     = val_reg;
        idx_next     = idx_reg;
        zcnt_next    = zcnt_reg;
        has_val_next = has_val_reg;
        err_next     = err_reg;

        case (state_reg)
            DC_WAIT: begin
                if (sym_valid) begin
                    // Predictor wraps mod 2^12. The new predictor is the DC output.
                    pred_next  = pred_reg + value;
                    val_next   = pred_reg + value;
                    idx_next   = 6'd0;
                    state_next = DC_OUT;
                    if (size_bad) err_next = 1'b1;
                end
            end

            DC_OUT: begin
                if (coef_ready) begin
                    idx_next   = 6'd1;
                    state_next = AC_WAIT;
                end
            end

            AC_WAIT: begin
                if (sym_valid) begin
                    if (size_bad || illegal_rl || overrun) err_next = 1'b1;
                    val_next = value;
                    if (is_eob_like || overrun) begin
                        // EOB, illegal (r,0) and overrun all fill zeros
                        // through 63. Any value is dropped.
                        zcnt_next    = fill_cnt;
                        has_val_next = 1'b0;
                        state_next   = ZERO_RUN;
                    end else if (is_zrl) begin
                        zcnt_next    = 6'd16;
                        has_val_next = 1'b0;
                        state_next   = ZERO_RUN;
                    end else if (run_length == 4'd0) begin
                        state_next   = VAL_OUT;
                    end else begin
                        zcnt_next    = {2'b00, run_length};
                        has_val_next = 1'b1;
                        state_next   = ZERO_RUN;
                    end
                end
            end

            ZERO_RUN: begin
                if (coef_ready) begin
                    if (zcnt_reg == 6'd1) begin
                        if (has_val_reg) begin
                            idx_next   = idx_reg + 6'd1;
                            state_next = VAL_OUT;
                        end else if (idx_reg == 6'd63) begin
                            idx_next   = 6'd0;
                            state_next = DC_WAIT;
                        end else begin
                            idx_next   = idx_reg + 6'd1;
                            state_next = AC_WAIT;
                        end
                    end else begin
                        zcnt_next = zcnt_reg - 6'd1;
                        idx_next  = idx_reg + 6'd1;
                    end
                end
            end

            VAL_OUT: begin
                if (coef_ready) begin
                    if (idx_reg == 6'd63) begin
                        idx_next   = 6'd0;
                        state_next = DC_WAIT;
                    end else begin
                        idx_next   = idx_reg + 6'd1;
                        state_next = AC_WAIT;
                    end
                end
            end

            default: state_next = DC_WAIT;
        endcase

        // Restart wins over everything except reset. It drops the shown
        // coefficient and ignores any symbol presented in the same cycle.
        if (restart_s) begin
            state_next   = DC_WAIT;
            pred_next    = 12'd0;
            val_next     = 12'd0;
            idx_next     = 6'd0;
            zcnt_next    = 6'd0;
            has_val_next = 1'b0;
            err_next     = 1'b0;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        sym_ready  = ((state_reg == DC_WAIT) || (state_reg == AC_WAIT)) && !restart_s;
        coef_valid = (state_reg == DC_OUT) || (state_reg == ZERO_RUN) ||
                     (state_reg == VAL_OUT);
        coef_data  = ((state_reg == DC_OUT) || (state_reg == VAL_OUT)) ? val_reg : 12'd0;
        coef_index = idx_reg;
        block_end  = coef_valid && (idx_reg == 6'd63);
        err        = err_reg;
    end

endmodule
